// File: rtl/fetch_unit.sv
// Program counter and fetch stage in front of the instruction ROM; hands words to decode via valid/accept.
// Optional fetch_cnt output (count of accepted instructions) is built when FETCH_CNT_EN is defined.
`timescale 1ns/1ps
module fetch_unit #(
   parameter int DWIDTH   = 16,
   parameter int AWIDTH   = 16,
   parameter int DEPTH    = 32,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic [AWIDTH-1:0] rom_addr_o,
   output logic              rom_ready_o,
   input  logic [DWIDTH-1:0] rom_dout,
   input  logic              rom_valid,
   output logic [DWIDTH-1:0] instr,
   output logic [AWIDTH-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_accept,
   input  logic              branch_taken,
   input  logic [AWIDTH-1:0] branch_target,
   output logic              addr_err
`ifdef FETCH_CNT_EN
   ,
   output logic [15:0]       fetch_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   localparam logic [AWIDTH-1:0] LAST_PC  = AWIDTH'(DEPTH - 1);
   localparam logic [AWIDTH-1:0] START_PC = AWIDTH'(RESET_PC);
   localparam logic [AWIDTH:0]   DEPTH_X  = (AWIDTH + 1)'(DEPTH);

   state_t            state_reg, state_next;
   logic [AWIDTH-1:0] pc_reg, pc_next;
   logic [DWIDTH-1:0] instr_reg, instr_next;
   logic [AWIDTH-1:0] instr_pc_reg, instr_pc_next;
   logic              instr_valid_reg, instr_valid_next;
   logic              addr_err_reg, addr_err_next;

   logic [AWIDTH-1:0] pc_inc;
   logic              branch_oob;
   logic [AWIDTH-1:0] branch_pc;

   // Out-of-range targets are compared one bit wider so DEPTH == 2**AWIDTH still works.
   assign pc_inc     = (pc_reg == LAST_PC) ? '0 : pc_reg + 1'b1;
   assign branch_oob = ({1'b0, branch_target} >= DEPTH_X);
   assign branch_pc  = branch_oob ? '0 : branch_target;

   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      instr_next       = instr_reg;
      instr_pc_next    = instr_pc_reg;
      instr_valid_next = instr_valid_reg;
      addr_err_next    = addr_err_reg;

      if (branch_taken) begin
         pc_next = branch_pc;
         if (branch_oob) begin
            addr_err_next = 1'b1;
         end
      end

      case (state_reg)
         IDLE: begin
            if (run) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            if (!branch_taken && rom_valid) begin
               instr_next       = rom_dout;
               instr_pc_next    = pc_reg;
               pc_next          = pc_inc;
               instr_valid_next = 1'b1;
               state_next       = HOLD;
            end
         end
         HOLD: begin
            // A redirect discards the held word even if decode accepts it this cycle.
            if (branch_taken || instr_accept) begin
               instr_valid_next = 1'b0;
               state_next       = run ? FETCH : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg       <= IDLE;
         pc_reg          <= START_PC;
         instr_reg       <= '0;
         instr_pc_reg    <= '0;
         instr_valid_reg <= 1'b0;
         addr_err_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         instr_reg       <= instr_next;
         instr_pc_reg    <= instr_pc_next;
         instr_valid_reg <= instr_valid_next;
         addr_err_reg    <= addr_err_next;
      end
   end

`ifdef FETCH_CNT_EN
   logic [15:0] fetch_cnt_reg;
   logic        accept_evt;

   assign accept_evt = (state_reg == HOLD) && instr_accept && !branch_taken;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_cnt_reg <= '0;
      end else if (accept_evt && (fetch_cnt_reg != 16'hFFFF)) begin
         fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
      end
   end

   assign fetch_cnt = fetch_cnt_reg;
`endif

   assign rom_addr_o  = pc_reg;
   assign rom_ready_o = (state_reg == FETCH);
   assign instr       = instr_reg;
   assign instr_pc    = instr_pc_reg;
   assign instr_valid = instr_valid_reg;
   assign addr_err    = addr_err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: table of per-cycle stimulus/expectations plus reset sequences.
`timescale 1ns/1ps
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [15:0] rom_addr_o;
   logic        rom_ready_o;
   logic [15:0] rom_dout;
   logic        rom_valid;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_accept;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        addr_err;
`ifdef FETCH_CNT_EN
   logic [15:0] fetch_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_unit #(.DWIDTH(16), .AWIDTH(16), .DEPTH(32), .RESET_PC(0)) dut (
      .clk           (clk),
      .rst           (rst),
      .run           (run),
      .rom_addr_o    (rom_addr_o),
      .rom_ready_o   (rom_ready_o),
      .rom_dout      (rom_dout),
      .rom_valid     (rom_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_accept  (instr_accept),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .addr_err      (addr_err)
`ifdef FETCH_CNT_EN
      ,
      .fetch_cnt     (fetch_cnt)
`endif
   );

   typedef struct {
      logic        run;
      logic        rv;
      logic [15:0] dout;
      logic        acc;
      logic        br;
      logic [15:0] tgt;
      logic        e_rdy;
      logic [15:0] e_addr;
      logic        e_iv;
      logic [15:0] e_instr;
      logic [15:0] e_ipc;
      logic        e_err;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic v, input logic [15:0] d, input logic a,
                      input logic b, input logic [15:0] t, input logic er, input logic [15:0] ea,
                      input logic eiv, input logic [15:0] ei, input logic [15:0] ep,
                      input logic ee, input logic [15:0] ec);
      vec_t x;
      x.run = r; x.rv = v; x.dout = d; x.acc = a; x.br = b; x.tgt = t;
      x.e_rdy = er; x.e_addr = ea; x.e_iv = eiv; x.e_instr = ei; x.e_ipc = ep;
      x.e_err = ee; x.e_cnt = ec;
      vecs.push_back(x);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      run = 1'b0; rom_valid = 1'b0; rom_dout = '0;
      instr_accept = 1'b0; branch_taken = 1'b0; branch_target = '0;
   endtask

   initial begin
      //   run rv dout     acc br tgt    | rdy addr iv instr    ipc err cnt
      add(1, 0, 16'h0000, 0, 0, 16'd0,   1, 16'd0,  0, 16'h0000, 16'd0,  0, 16'd0); // IDLE->FETCH
      add(1, 1, 16'h000A, 0, 0, 16'd0,   0, 16'd1,  1, 16'h000A, 16'd0,  0, 16'd0); // capture
      add(1, 0, 16'h0000, 1, 0, 16'd0,   1, 16'd1,  0, 16'h000A, 16'd0,  0, 16'd1); // accept
      add(1, 0, 16'h0000, 0, 0, 16'd0,   1, 16'd1,  0, 16'h000A, 16'd0,  0, 16'd1); // stall x3
      add(1, 0, 16'h0000, 0, 0, 16'd0,   1, 16'd1,  0, 16'h000A, 16'd0,  0, 16'd1);
      add(1, 0, 16'h0000, 0, 0, 16'd0,   1, 16'd1,  0, 16'h000A, 16'd0,  0, 16'd1);
      add(1, 1, 16'h1234, 0, 0, 16'd0,   0, 16'd2,  1, 16'h1234, 16'd1,  0, 16'd1);
      add(1, 0, 16'h0000, 0, 0, 16'd0,   0, 16'd2,  1, 16'h1234, 16'd1,  0, 16'd1); // hold
      add(1, 0, 16'h0000, 1, 1, 16'd31,  1, 16'd31, 0, 16'h1234, 16'd1,  0, 16'd1); // branch beats accept
      add(1, 1, 16'hBEEF, 0, 0, 16'd0,   0, 16'd0,  1, 16'hBEEF, 16'd31, 0, 16'd1); // wrap 31->0
      add(1, 0, 16'h0000, 1, 0, 16'd0,   1, 16'd0,  0, 16'hBEEF, 16'd31, 0, 16'd2);
      add(1, 1, 16'h00AA, 0, 0, 16'd0,   0, 16'd1,  1, 16'h00AA, 16'd0,  0, 16'd2);
      add(1, 0, 16'h0000, 1, 1, 16'd5,   1, 16'd5,  0, 16'h00AA, 16'd0,  0, 16'd2);
      add(1, 1, 16'hFFFF, 0, 1, 16'd40,  1, 16'd0,  0, 16'h00AA, 16'd0,  1, 16'd2); // oob, beats rom_valid
      add(0, 1, 16'h5A5A, 0, 0, 16'd0,   0, 16'd1,  1, 16'h5A5A, 16'd0,  1, 16'd2); // run ignored in FETCH
      add(0, 0, 16'h0000, 1, 0, 16'd0,   0, 16'd1,  0, 16'h5A5A, 16'd0,  1, 16'd3); // HOLD->IDLE
      add(0, 0, 16'h0000, 0, 1, 16'd7,   0, 16'd7,  0, 16'h5A5A, 16'd0,  1, 16'd3); // branch in IDLE
      add(1, 0, 16'h0000, 0, 0, 16'd0,   1, 16'd7,  0, 16'h5A5A, 16'd0,  1, 16'd3);
      add(1, 1, 16'hD600, 0, 0, 16'd0,   0, 16'd8,  1, 16'hD600, 16'd7,  1, 16'd3);

      idle_inputs();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      chk("reset rdy",   {31'd0, rom_ready_o}, 32'd0);
      chk("reset addr",  {16'd0, rom_addr_o},  32'd0);
      chk("reset iv",    {31'd0, instr_valid}, 32'd0);
      chk("reset err",   {31'd0, addr_err},    32'd0);
      $display("reset released: rdy=%0d addr=%0d iv=%0d err=%0d", rom_ready_o, rom_addr_o, instr_valid, addr_err);

      for (int i = 0; i < vecs.size(); i++) begin
         run = vecs[i].run; rom_valid = vecs[i].rv; rom_dout = vecs[i].dout;
         instr_accept = vecs[i].acc; branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
         step();
         chk($sformatf("row%0d rdy", i),   {31'd0, rom_ready_o}, {31'd0, vecs[i].e_rdy});
         chk($sformatf("row%0d addr", i),  {16'd0, rom_addr_o},  {16'd0, vecs[i].e_addr});
         chk($sformatf("row%0d iv", i),    {31'd0, instr_valid}, {31'd0, vecs[i].e_iv});
         chk($sformatf("row%0d instr", i), {16'd0, instr},       {16'd0, vecs[i].e_instr});
         chk($sformatf("row%0d ipc", i),   {16'd0, instr_pc},    {16'd0, vecs[i].e_ipc});
         chk($sformatf("row%0d err", i),   {31'd0, addr_err},    {31'd0, vecs[i].e_err});
`ifdef FETCH_CNT_EN
         chk($sformatf("row%0d cnt", i),   {16'd0, fetch_cnt},   {16'd0, vecs[i].e_cnt});
`endif
         $display("row %0d: addr=%0d rdy=%0d iv=%0d instr=%h ipc=%0d err=%0d",
                  i, rom_addr_o, rom_ready_o, instr_valid, instr, instr_pc, addr_err);
      end

      // Reset while HOLD has 16'hD600 waiting: word dropped, PC back to 0.
      idle_inputs();
      rst = 1'b0;
      step();
      chk("hold rst iv",    {31'd0, instr_valid}, 32'd0);
      chk("hold rst addr",  {16'd0, rom_addr_o},  32'd0);
      chk("hold rst rdy",   {31'd0, rom_ready_o}, 32'd0);
      chk("hold rst instr", {16'd0, instr},       32'd0);
      chk("hold rst err",   {31'd0, addr_err},    32'd0);
      $display("reset in HOLD: iv=%0d addr=%0d instr=%h", instr_valid, rom_addr_o, instr);

      rst = 1'b1;
      run = 1'b1;
      step();
      chk("refetch rdy", {31'd0, rom_ready_o}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         rom_valid = 1'b1;
         rom_dout = 16'h0100 + 16'(k);
         step();
         chk($sformatf("seq%0d instr", k), {16'd0, instr},       32'h100 + k);
         chk($sformatf("seq%0d ipc", k),   {16'd0, instr_pc},    k);
         chk($sformatf("seq%0d iv", k),    {31'd0, instr_valid}, 32'd1);
         rom_valid = 1'b0;
         instr_accept = 1'b1;
         step();
         instr_accept = 1'b0;
         chk($sformatf("seq%0d acc iv", k), {31'd0, instr_valid}, 32'd0);
         chk($sformatf("seq%0d addr", k),   {16'd0, rom_addr_o},  k + 1);
         $display("accept %0d: instr=%h ipc=%0d addr=%0d", k, instr, instr_pc, rom_addr_o);
      end
`ifdef FETCH_CNT_EN
      chk("cnt after 3", {16'd0, fetch_cnt}, 32'd3);
`endif

      // Reset while in FETCH.
      rst = 1'b0;
      step();
      chk("fetch rst rdy",  {31'd0, rom_ready_o}, 32'd0);
      chk("fetch rst addr", {16'd0, rom_addr_o},  32'd0);
      $display("reset in FETCH: rdy=%0d addr=%0d", rom_ready_o, rom_addr_o);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
